// File: rtl/xdcr_out_gate.sv
// Output gate between the PWM generator and the transducer pins: staggered
// group ramp-up/down, glitch-free per-channel gating, and a hard fault cut-off.
//
// state     | meaning
// S_IDLE    | all gates closed, waiting for ENABLE
// S_RAMP_UP | opening one group every STEP_TICKS cycles, lowest group first
// S_ON      | all groups open
// S_RAMP_DOWN | closing one group every STEP_TICKS cycles, highest group first
// S_FAULT   | hard cut; leaves only once FORCE_OFF and ENABLE are both low
module xdcr_out_gate #(
    parameter int TRANS_NUM  = 249,
    parameter int GROUP_SIZE = 16,
    parameter int STEP_TICKS = 2048
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 ENABLE,
    input  logic                 FORCE_OFF,
    input  logic [TRANS_NUM-1:0] PWM_IN,
    output logic [TRANS_NUM-1:0] PWM_OUT,
    output logic                 ACTIVE,
    output logic                 BUSY,
    output logic                 FAULT
);

    localparam int NUM_GROUPS = (TRANS_NUM + GROUP_SIZE - 1) / GROUP_SIZE;
    localparam int GW         = $clog2(NUM_GROUPS + 1);
    localparam int TW         = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [GW-1:0] GRP_MAX   = GW'(NUM_GROUPS);
    localparam logic [GW-1:0] GRP_ONE   = GW'(1);
    localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAMP_UP,
        S_ON,
        S_RAMP_DOWN,
        S_FAULT
    } state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        grp_cnt, grp_d;
    logic [TW-1:0]        tick, tick_d;
    logic [TRANS_NUM-1:0] gate;
    logic [TRANS_NUM-1:0] target;

    always_comb begin
        state_d = state_q;
        grp_d   = grp_cnt;
        tick_d  = tick;
        if (FORCE_OFF) begin
            state_d = S_FAULT;
            grp_d   = '0;
            tick_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ENABLE) begin
                        state_d = S_RAMP_UP;
                        grp_d   = GRP_ONE;
                        tick_d  = '0;
                    end
                end
                S_RAMP_UP: begin
                    if (!ENABLE) begin
                        state_d = S_RAMP_DOWN;
                        tick_d  = '0;
                    end else if (tick == TICK_LAST) begin
                        tick_d = '0;
                        if (grp_cnt == GRP_MAX) state_d = S_ON;
                        else                    grp_d   = grp_cnt + 1'b1;
                    end else begin
                        tick_d = tick + 1'b1;
                    end
                end
                S_ON: begin
                    if (!ENABLE) begin
                        state_d = S_RAMP_DOWN;
                        tick_d  = '0;
                    end
                end
                S_RAMP_DOWN: begin
                    if (ENABLE) begin
                        state_d = S_RAMP_UP;
                        tick_d  = '0;
                    end else if (tick == TICK_LAST) begin
                        tick_d = '0;
                        grp_d  = grp_cnt - 1'b1;
                        if (grp_cnt == GRP_ONE) state_d = S_IDLE;
                    end else begin
                        tick_d = tick + 1'b1;
                    end
                end
                S_FAULT: begin
                    if (!ENABLE) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            grp_cnt <= '0;
            tick    <= '0;
            ACTIVE  <= 1'b0;
            BUSY    <= 1'b0;
            FAULT   <= 1'b0;
        end else begin
            state_q <= state_d;
            grp_cnt <= grp_d;
            tick    <= tick_d;
            ACTIVE  <= (state_d == S_ON);
            BUSY    <= (state_d == S_RAMP_UP) || (state_d == S_RAMP_DOWN);
            FAULT   <= (state_d == S_FAULT);
        end
    end

    for (genvar i = 0; i < TRANS_NUM; i++) begin : g_ch
        localparam logic [GW-1:0] GRP_IDX = GW'(i / GROUP_SIZE);
        assign target[i] = (GRP_IDX < grp_cnt);
    end

    // A gate may only move while its input is low, so pulses are never cut or started late.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            gate    <= '0;
            PWM_OUT <= '0;
        end else if (FORCE_OFF) begin
            gate    <= '0;
            PWM_OUT <= '0;
        end else begin
            gate    <= (gate & PWM_IN) | (target & ~PWM_IN);
            PWM_OUT <= PWM_IN & gate;
        end
    end

endmodule

// File: tb/tb_xdcr_out_gate.sv
// Scoreboard bench for xdcr_out_gate: directed timeline, hand-derived expectations
// queued per cycle and compared by an independent negedge monitor.
module tb_xdcr_out_gate;

    localparam int TRANS_NUM = 249;

    logic                 clk;
    logic                 rst_n;
    logic                 en;
    logic                 force_off;
    logic [TRANS_NUM-1:0] pwm_in;
    logic [TRANS_NUM-1:0] pwm_out1, pwm_out2;
    logic                 active1, busy1, fault1;
    logic                 active2, busy2, fault2;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   done = 0;
    bit   run_chk_en = 0;
    int   run [TRANS_NUM];

    typedef struct {
        int         cyc;
        int         kind;
        int         ch;
        logic [2:0] exp;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    xdcr_out_gate #(.TRANS_NUM(TRANS_NUM), .GROUP_SIZE(16), .STEP_TICKS(4)) dut1 (
        .CLK(clk), .RESET_N(rst_n), .ENABLE(en), .FORCE_OFF(force_off),
        .PWM_IN(pwm_in), .PWM_OUT(pwm_out1),
        .ACTIVE(active1), .BUSY(busy1), .FAULT(fault1)
    );

    xdcr_out_gate #(.TRANS_NUM(TRANS_NUM), .GROUP_SIZE(16), .STEP_TICKS(1)) dut2 (
        .CLK(clk), .RESET_N(rst_n), .ENABLE(en), .FORCE_OFF(force_off),
        .PWM_IN(pwm_in), .PWM_OUT(pwm_out2),
        .ACTIVE(active2), .BUSY(busy2), .FAULT(fault2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Shared PWM: period 10, high for phases 0..2 of the bench cycle count.
    initial begin
        pwm_in = '0;
        forever begin
            @(posedge clk);
            #1;
            if ((cyc % 10) < 3) pwm_in = '1;
            else                pwm_in = '0;
        end
    end

    task automatic push(input int c, input int kind, input int ch, input logic [2:0] v,
                        input string nm);
        exp_t e;
        e.cyc = c; e.kind = kind; e.ch = ch; e.exp = v; e.name = nm;
        exp_q.push_back(e);
    endtask

    // flags are {ACTIVE,BUSY,FAULT}
    task automatic ef(input int c, input logic [2:0] v, input string nm);
        push(c, 0, 0, v, nm);
    endtask
    task automatic ec(input int c, input int ch, input logic v, input string nm);
        push(c, 1, ch, {2'b00, v}, nm);
    endtask
    task automatic ez(input int c, input string nm);
        push(c, 2, 0, 3'b001, nm);
    endtask
    task automatic e2(input int c, input logic [2:0] v, input string nm);
        push(c, 3, 0, v, nm);
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [2:0] act;
        for (int c = 0; c < TRANS_NUM; c++) run[c] = 0;
        forever begin
            @(negedge clk);
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].cyc == cyc) begin
                    case (exp_q[i].kind)
                        0:       act = {active1, busy1, fault1};
                        1:       act = {2'b00, pwm_out1[exp_q[i].ch]};
                        2:       act = {2'b00, (pwm_out1 == '0)};
                        default: act = {active2, busy2, fault2};
                    endcase
                    checks++;
                    if (act !== exp_q[i].exp) begin
                        failures++;
                        $display("FAIL %s cyc=%0d actual=%b required=%b",
                                 exp_q[i].name, cyc, act, exp_q[i].exp);
                    end
                    exp_q.delete(i);
                end
            end
            for (int c = 0; c < TRANS_NUM; c++) begin
                if (!run_chk_en) begin
                    run[c] = 0;
                end else if (pwm_out1[c]) begin
                    run[c]++;
                end else if (run[c] > 0) begin
                    checks++;
                    if (run[c] != 3) begin
                        failures++;
                        $display("FAIL pulse_len ch=%0d cyc=%0d actual=%0d required=3",
                                 c, cyc, run[c]);
                    end
                    run[c] = 0;
                end
            end
            if (done) begin
                checks++;
                if (exp_q.size() != 0) begin
                    failures++;
                    $display("FAIL unchecked_expectations actual=%0d required=0", exp_q.size());
                end
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    initial begin
        rst_n = 1'b1; en = 1'b0; force_off = 1'b0;
        #2 rst_n = 1'b0;
        ef(2, 3'b000, "rst_flags");
        ez(2, "rst_out");
        wait_to(3);
        #1 rst_n = 1'b1;
        run_chk_en = 1'b1;
        ef(50, 3'b000, "idle_flags");
        ez(50, "idle_out");

        // ramp up: ENABLE sampled at edge 100
        wait_to(99);
        ef(99,  3'b000, "up_pre");
        ef(100, 3'b010, "up_busy_start");
        ef(163, 3'b010, "up_busy_end");
        ef(164, 3'b100, "up_active");
        e2(100, 3'b010, "st1_busy_start");
        e2(115, 3'b010, "st1_busy_end");
        e2(116, 3'b100, "st1_active");
        ec(101, 0,   1'b0, "ch0_no_midpulse");
        ec(111, 0,   1'b1, "ch0_first_pulse");
        ec(113, 0,   1'b1, "ch0_pulse_end");
        ec(114, 0,   1'b0, "ch0_after_pulse");
        ec(111, 48,  1'b0, "ch48_not_yet");
        ec(121, 48,  1'b1, "ch48_first_pulse");
        ec(161, 239, 1'b1, "ch239_first_pulse");
        ec(161, 248, 1'b0, "ch248_not_yet");
        ec(171, 248, 1'b1, "ch248_first_pulse");
        en = 1'b1;

        // ramp down from ON: ENABLE low sampled at edge 200
        wait_to(199);
        ef(199, 3'b100, "down_pre");
        ef(200, 3'b010, "down_busy_start");
        ef(263, 3'b010, "down_busy_end");
        ef(264, 3'b000, "down_idle");
        e2(215, 3'b010, "st1_down_busy");
        e2(216, 3'b000, "st1_down_idle");
        ec(201, 248, 1'b1, "ch248_last_pulse");
        ec(211, 248, 1'b0, "ch248_off");
        ec(211, 224, 1'b0, "ch224_off");
        ec(211, 208, 1'b1, "ch208_still_on");
        ec(221, 208, 1'b0, "ch208_off");
        ec(261, 0,   1'b1, "ch0_last_pulse");
        ec(271, 0,   1'b0, "ch0_off");
        ez(281, "down_all_zero");
        en = 1'b0;

        // interrupted ramp: drop at grp_cnt=5 (edge 318), reassert at edge 324
        wait_to(299);
        ef(318, 3'b010, "int_down_busy");
        ef(324, 3'b010, "int_up_busy");
        ef(372, 3'b010, "int_not_early");
        ef(375, 3'b010, "int_busy_end");
        ef(376, 3'b100, "int_active");
        e2(316, 3'b100, "st1_int_on");
        e2(318, 3'b010, "st1_int_down");
        e2(329, 3'b010, "st1_int_busy_end");
        e2(330, 3'b100, "st1_int_active");
        en = 1'b1;
        wait_to(317);
        en = 1'b0;
        wait_to(323);
        en = 1'b1;

        // FORCE_OFF mid-pulse: sampled at edge 382
        wait_to(380);
        run_chk_en = 1'b0;
        ec(381, 0, 1'b1, "force_midpulse");
        ef(381, 3'b100, "force_pre");
        ez(382, "force_cut");
        ef(382, 3'b001, "force_fault");
        e2(382, 3'b001, "st1_force_fault");
        ef(386, 3'b001, "fault_hold_en");
        ez(391, "fault_out_zero");
        ef(392, 3'b001, "fault_hold_end");
        ef(393, 3'b000, "fault_to_idle");
        e2(393, 3'b000, "st1_fault_to_idle");
        wait_to(381);
        force_off = 1'b1;
        wait_to(385);
        force_off = 1'b0;
        wait_to(392);
        en = 1'b0;
        wait_to(395);
        run_chk_en = 1'b1;

        // async reset between edges during RAMP_UP
        wait_to(409);
        ef(410, 3'b010, "rr_busy");
        ez(421, "rr_async_out");
        ef(421, 3'b000, "rr_async_flags");
        ef(424, 3'b000, "rr_held");
        ef(426, 3'b010, "rr_restart_busy");
        ec(431, 0,  1'b1, "rr_ch0_pulse");
        ec(431, 16, 1'b0, "rr_ch16_not_yet");
        ec(441, 16, 1'b1, "rr_ch16_pulse");
        ef(489, 3'b010, "rr_busy_end");
        ef(490, 3'b100, "rr_active");
        e2(441, 3'b010, "st1_rr_busy_end");
        e2(442, 3'b100, "st1_rr_active");
        en = 1'b1;
        wait_to(419);
        run_chk_en = 1'b0;
        wait_to(421);
        #2 rst_n = 1'b0;
        wait_to(425);
        #2 rst_n = 1'b1;
        wait_to(428);
        run_chk_en = 1'b1;

        wait_to(500);
        done = 1'b1;
    end

endmodule
